// File: rtl/aes_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_pkg : widths, FSM encoding and sizing helper shared by aes_enc_arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_KEY_W   = 128;
  localparam int AES_BLOCK_W = 128;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_KEY_INIT  = 3'd1,
    ST_KEY_WAIT  = 3'd2,
    ST_BLK_START = 3'd3,
    ST_BLK_WAIT  = 3'd4,
    ST_RESP      = 3'd5
  } aes_state_e;

  function automatic int src_w(input int n_req);
    return (n_req > 2) ? $clog2(n_req) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_rr_arbiter : combinational round-robin pick starting at rr_ptr
// Revision: 1.0
// ---------------------------------------------------------------------------
module aes_rr_arbiter
  import aes_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int SRC_W = 1
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [SRC_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [SRC_W-1:0] grant_idx,
  output logic             grant_any
);

  // Walk offsets from the far end so the closest requester to rr_ptr wins last.
  always_comb begin : p_pick
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      idx = (int'(rr_ptr) + off) % N_REQ;
      if (req_valid[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = SRC_W'(idx);
        grant_any  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/aes_enc_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_enc_arbiter : round-robin sharing of one AES core with key caching
// Revision: 1.0
// ---------------------------------------------------------------------------
module aes_enc_arbiter
  import aes_pkg::*;
#(
  parameter  int N_REQ   = 2,
  parameter  int TIMEOUT = 255,
  localparam int SRC_W   = src_w(N_REQ)
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*AES_KEY_W-1:0]   req_key,
  input  logic [N_REQ*AES_BLOCK_W-1:0] req_block,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [AES_BLOCK_W-1:0]       rsp_data,
  output logic [SRC_W-1:0]             rsp_src,
  output logic                         rsp_err,
  output logic [AES_KEY_W-1:0]         core_key,
  output logic                         core_key_init,
  input  logic                         core_key_ready,
  output logic [AES_BLOCK_W-1:0]       core_block,
  output logic                         core_next,
  input  logic [AES_BLOCK_W-1:0]       core_result,
  input  logic                         core_block_ready
);

  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  aes_state_e             state_q, state_d;
  logic [AES_KEY_W-1:0]   key_q, key_d, loaded_key_q, loaded_key_d;
  logic [AES_BLOCK_W-1:0] blk_q, blk_d, rsp_data_q, rsp_data_d;
  logic [SRC_W-1:0]       src_q, src_d, rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic                   loaded_valid_q, loaded_valid_d;
  logic                   rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic                   key_init_q, key_init_d, next_q, next_d;

  logic [N_REQ-1:0] grant;
  logic [SRC_W-1:0] grant_idx;
  logic             grant_any;

  aes_rr_arbiter #(
    .N_REQ (N_REQ),
    .SRC_W (SRC_W)
  ) u_rr (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  always_comb begin
    state_d        = state_q;
    key_d          = key_q;
    blk_d          = blk_q;
    src_d          = src_q;
    loaded_key_d   = loaded_key_q;
    loaded_valid_d = loaded_valid_q;
    rr_ptr_d       = rr_ptr_q;
    wait_cnt_d     = wait_cnt_q;
    rsp_data_d     = rsp_data_q;
    rsp_err_d      = rsp_err_q;
    req_ready      = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_any && aresetn) begin
          req_ready = grant;
          key_d     = req_key[int'(grant_idx)*AES_KEY_W +: AES_KEY_W];
          blk_d     = req_block[int'(grant_idx)*AES_BLOCK_W +: AES_BLOCK_W];
          src_d     = grant_idx;
          state_d   = (!loaded_valid_q || key_d != loaded_key_q) ? ST_KEY_INIT : ST_BLK_START;
        end
      end
      ST_KEY_INIT: begin
        wait_cnt_d = '0;
        state_d    = ST_KEY_WAIT;
      end
      ST_KEY_WAIT: begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
        // The core's ready is stale during the first cycle after the pulse.
        if (wait_cnt_q != '0 && core_key_ready) begin
          loaded_key_d   = key_q;
          loaded_valid_d = 1'b1;
          state_d        = ST_BLK_START;
        end else if (wait_cnt_q == TIMEOUT_CNT) begin
          rsp_err_d      = 1'b1;
          rsp_data_d     = '0;
          loaded_valid_d = 1'b0;
          state_d        = ST_RESP;
        end
      end
      ST_BLK_START: begin
        wait_cnt_d = '0;
        state_d    = ST_BLK_WAIT;
      end
      ST_BLK_WAIT: begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
        if (wait_cnt_q != '0 && core_block_ready) begin
          rsp_data_d = core_result;
          rsp_err_d  = 1'b0;
          state_d    = ST_RESP;
        end else if (wait_cnt_q == TIMEOUT_CNT) begin
          rsp_err_d      = 1'b1;
          rsp_data_d     = '0;
          loaded_valid_d = 1'b0;
          state_d        = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rr_ptr_d = (src_q == SRC_W'(N_REQ - 1)) ? '0 : src_q + SRC_W'(1);
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Pulses and valid follow the state being entered so they leave a flop.
    key_init_d  = (state_d == ST_KEY_INIT);
    next_d      = (state_d == ST_BLK_START);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q        <= ST_IDLE;
      key_q          <= '0;
      blk_q          <= '0;
      src_q          <= '0;
      loaded_key_q   <= '0;
      loaded_valid_q <= 1'b0;
      rr_ptr_q       <= '0;
      wait_cnt_q     <= '0;
      rsp_data_q     <= '0;
      rsp_err_q      <= 1'b0;
      rsp_valid_q    <= 1'b0;
      key_init_q     <= 1'b0;
      next_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      key_q          <= key_d;
      blk_q          <= blk_d;
      src_q          <= src_d;
      loaded_key_q   <= loaded_key_d;
      loaded_valid_q <= loaded_valid_d;
      rr_ptr_q       <= rr_ptr_d;
      wait_cnt_q     <= wait_cnt_d;
      rsp_data_q     <= rsp_data_d;
      rsp_err_q      <= rsp_err_d;
      rsp_valid_q    <= rsp_valid_d;
      key_init_q     <= key_init_d;
      next_q         <= next_d;
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_src       = src_q;
  assign rsp_err       = rsp_err_q;
  assign core_key      = key_q;
  assign core_block    = blk_q;
  assign core_key_init = key_init_q;
  assign core_next     = next_q;

endmodule
`default_nettype wire
